// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode event queue.
// Event format, FSM encoding and a small event constructor.
package keycode_pkg;

  localparam logic [7:0] NO_KEY = 8'h00;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_REL = 2'd1,
    PUSH_PRS = 2'd2
  } kstate_t;

  function automatic key_evt_t make_evt(input logic press, input logic [7:0] code);
    key_evt_t e;
    e.press = press;
    e.code  = code;
    return e;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous FIFO of key events with a combinational drop pulse.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module key_evt_fifo
  import keycode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  key_evt_t                 din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count,
  output key_evt_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = empty ? make_evt(1'b0, NO_KEY) : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth makes wrap implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed through head while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces the USB keycode PIO and emits press/release events into a FIFO.
// Holds the stability filter, the event-push FSM and the sticky overflow flag.
module keycode_event_queue
  import keycode_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [7:0]                    keycode_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_press,
  output logic [7:0]                    held_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  logic [7:0]    cand;
  logic [SW-1:0] stab;
  logic [7:0]    old_code;
  kstate_t       state;
  kstate_t       next_state;
  logic          commit;
  logic          push;
  key_evt_t      push_evt;
  logic          full;
  logic          empty;
  logic          drop;
  key_evt_t      head;

  // Stability filter: restart on any change, otherwise count up and saturate.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cand <= NO_KEY;
      stab <= '0;
    end else if (keycode_in != cand) begin
      cand <= keycode_in;
      stab <= '0;
    end else if (stab != STAB_MAX) begin
      stab <= stab + 1'b1;
    end else begin
      stab <= stab;
    end
  end

  assign commit = (stab == STAB_MAX) && (keycode_in == cand) &&
                  (cand != held_code) && (state == IDLE);

  // FSM state plus the accepted/previous keycode captured at commit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state     <= IDLE;
      held_code <= NO_KEY;
      old_code  <= NO_KEY;
    end else begin
      state <= next_state;
      if (commit) begin
        held_code <= cand;
        old_code  <= held_code;
      end
    end
  end

  // Next-state and push generation; release of the old key always precedes the new press.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_evt   = make_evt(1'b0, NO_KEY);
    case (state)
      IDLE: begin
        if (commit && (held_code != NO_KEY)) begin
          next_state = PUSH_REL;
        end else if (commit && (cand != NO_KEY)) begin
          next_state = PUSH_PRS;
        end else begin
          next_state = IDLE;
        end
      end
      PUSH_REL: begin
        push     = 1'b1;
        push_evt = make_evt(1'b0, old_code);
        if (held_code != NO_KEY) begin
          next_state = PUSH_PRS;
        end else begin
          next_state = IDLE;
        end
      end
      PUSH_PRS: begin
        push       = 1'b1;
        push_evt   = make_evt(1'b1, held_code);
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (push),
    .din   (push_evt),
    .pop   (evt_ready),
    .full  (full),
    .empty (empty),
    .drop  (drop),
    .count (fifo_count),
    .head  (head)
  );

  // Sticky overflow; a drop in the same cycle wins over the clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  assign evt_valid = !empty;
  assign evt_code  = head.code;
  assign evt_press = head.press;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with STABLE_CYCLES=4, FIFO_DEPTH=4.
module tb_keycode_event_queue;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic [7:0] keycode_in = 8'h00;
  logic       evt_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_press;
  logic [7:0] held_code;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail = 0;

  keycode_event_queue #(
    .STABLE_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .keycode_in   (keycode_in),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_press    (evt_press),
    .held_code    (held_code),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    evt_ready = 1'b0;
    overflow_clr = 1'b0;
    keycode_in = 8'h00;
    tick(2);
    reset_reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({evt_valid, evt_code, evt_press, held_code, fifo_count, overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b c=%h p=%b h=%h n=%0d o=%b want all zero",
               evt_valid, evt_code, evt_press, held_code, fifo_count, overflow);
    end
    do_reset();
  endtask

  task automatic test_basic_press();
    int seen;
    do_reset();
    evt_ready = 1'b1;
    keycode_in = 8'h04;
    tick(4);
    n_checks++;
    if (held_code !== 8'h00) begin n_fail++; $display("FAIL basic_held_early: got %h want 00", held_code); end
    tick(1);
    n_checks++;
    if (held_code !== 8'h04 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_held_edge4: got h=%h v=%b want h=04 v=0", held_code, evt_valid);
    end
    tick(1);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h04 || evt_press !== 1'b1) begin
      n_fail++; $display("FAIL basic_event: got v=%b c=%h p=%b want v=1 c=04 p=1", evt_valid, evt_code, evt_press);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (evt_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL basic_single: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic test_glitch();
    int seen;
    do_reset();
    evt_ready = 1'b1;
    keycode_in = 8'h04;
    tick(3);
    keycode_in = 8'h00;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (evt_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0 || held_code !== 8'h00) begin
      n_fail++; $display("FAIL glitch_reject: got events=%0d h=%h want events=0 h=00", seen, held_code);
    end
  endtask

  task automatic test_key_change();
    do_reset();
    evt_ready = 1'b1;
    keycode_in = 8'h04;
    tick(6);
    keycode_in = 8'h16;
    tick(5);
    n_checks++;
    if (held_code !== 8'h16 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL change_held: got h=%h v=%b want h=16 v=0", held_code, evt_valid);
    end
    tick(1);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h04 || evt_press !== 1'b0) begin
      n_fail++; $display("FAIL change_release: got v=%b c=%h p=%b want v=1 c=04 p=0", evt_valid, evt_code, evt_press);
    end
    tick(1);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h16 || evt_press !== 1'b1 || fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL change_press: got v=%b c=%h p=%b n=%0d want v=1 c=16 p=1 n=1",
                         evt_valid, evt_code, evt_press, fifo_count);
    end
    tick(1);
    n_checks++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL change_drain: got v=%b want 0", evt_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      keycode_in = (i % 2 == 0) ? 8'h04 : 8'h00;
      tick(8);
    end
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill: got n=%0d o=%b want n=4 o=0", fifo_count, overflow);
    end
    keycode_in = 8'h04;
    tick(8);
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || held_code !== 8'h04) begin
      n_fail++; $display("FAIL ovf_drop: got n=%0d o=%b h=%h want n=4 o=1 h=04", fifo_count, overflow, held_code);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 8'h04 || evt_press !== (i % 2 == 0)) begin
        n_fail++; $display("FAIL ovf_order[%0d]: got v=%b c=%h p=%b want v=1 c=04 p=%b",
                           i, evt_valid, evt_code, evt_press, (i % 2 == 0));
      end
      tick(1);
    end
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got v=%b o=%b want v=0 o=1", evt_valid, overflow);
    end
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      keycode_in = (i % 2 == 0) ? 8'h00 : 8'h04;
      tick(8);
    end
    keycode_in = 8'h00;
    tick(5);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || evt_code !== 8'h04 || evt_press !== 1'b1) begin
      n_fail++; $display("FAIL full_push_pop: got n=%0d o=%b c=%h p=%b want n=4 o=0 c=04 p=1",
                         fifo_count, overflow, evt_code, evt_press);
    end
    keycode_in = 8'h04;
    tick(5);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      n_fail++; $display("FAIL set_over_clr: got o=%b n=%0d want o=1 n=4", overflow, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    keycode_in = 8'h04;
    tick(8);
    keycode_in = 8'h16;
    tick(8);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    keycode_in = 8'h05;
    tick(5);
    n_checks++;
    if (fifo_count !== 3'd2 || held_code !== 8'h05) begin
      n_fail++; $display("FAIL mid_setup: got n=%0d h=%h want n=2 h=05", fifo_count, held_code);
    end
    reset_reset = 1'b1;
    keycode_in = 8'h00;
    #2;
    n_checks++;
    if ({evt_valid, evt_code, evt_press, held_code, fifo_count, overflow} !== 20'h0) begin
      n_fail++; $display("FAIL mid_async_reset: got v=%b c=%h p=%b h=%h n=%0d o=%b want all zero",
                         evt_valid, evt_code, evt_press, held_code, fifo_count, overflow);
    end
    tick(1);
    reset_reset = 1'b0;
    tick(12);
    n_checks++;
    if (evt_valid !== 1'b0 || held_code !== 8'h00 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL mid_no_event: got v=%b h=%h n=%0d want v=0 h=00 n=0", evt_valid, held_code, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_glitch();
    test_key_change();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
